riscv_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the instruction decoder.
- Maintains the PC and issues word-aligned requests to instruction memory under a valid/ready handshake.
- Buffers in-order responses in a small FIFO and presents {instr, pc} to the decoder with valid/ready.
- Supports a redirect (branch/jump) input that flushes buffered and in-flight fetches.

---
 rtl/riscv_fetch_unit.sv | 158 +++++++++++++++
 tb/tb_riscv_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, in-order response FIFO, redirect flush.
// Optional misaligned-redirect fault is built when FETCH_MISALIGN_CHECK_EN is defined.
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_fault
);

    localparam int unsigned     PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     CntW    = $clog2(DEPTH + 1);
    localparam logic [CntW:0]   DepthC  = (CntW + 1)'(DEPTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

    logic [31:0]     pc_q, pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] discard_q, discard_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [31:0]     data_q [DEPTH];
    logic [31:0]     pcs_q  [DEPTH];

    logic [31:0] redirect_aligned;
    logic [CntW:0] inflight;
    logic credit, accept, rsp_ok, drop, push, pop, empty;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q, fault_d;

    always_comb begin
        fault_d = fault_q;
        if (redirect_valid) begin
            fault_d = (redirect_pc[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fetch_fault = fault_q;
`else
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign fetch_fault = 1'b0;
`endif

    assign redirect_aligned = {redirect_pc[31:2], 2'b00};
    assign inflight = {1'b0, outstanding_q} + {1'b0, count_q};
    assign credit   = inflight < DepthC;
    assign empty    = (count_q == '0);

    assign imem_req_valid = !rst && !redirect_valid && credit && !fetch_fault;
    assign imem_req_addr  = pc_q;
    assign instr_valid    = !rst && !empty;
    assign instr          = empty ? 32'h0 : data_q[rptr_q];
    assign instr_pc       = empty ? 32'h0 : pcs_q[rptr_q];

    // Responses with nothing outstanding (e.g. stragglers across a reset) are ignored.
    assign accept = imem_req_valid && imem_req_ready;
    assign rsp_ok = imem_rsp_valid && (outstanding_q != '0);
    assign drop   = rsp_ok && (discard_q != '0);
    assign push   = rsp_ok && !drop && !redirect_valid;
    assign pop    = instr_valid && instr_ready && !redirect_valid;

    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;

        if (accept && !rsp_ok) begin
            outstanding_d = outstanding_q + CntOne;
        end else if (!accept && rsp_ok) begin
            outstanding_d = outstanding_q - CntOne;
        end

        if (redirect_valid) begin
            // Everything still in flight is stale; a response landing now is dropped here.
            pc_d      = redirect_aligned;
            resp_pc_d = redirect_aligned;
            discard_d = rsp_ok ? (outstanding_q - CntOne) : outstanding_q;
            count_d   = '0;
            wptr_d    = '0;
            rptr_d    = '0;
        end else begin
            if (accept) begin
                pc_d = pc_q + 32'd4;
            end
            if (drop) begin
                discard_d = discard_q - CntOne;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wptr_d    = (wptr_q == LastPtr) ? '0 : wptr_q + PtrOne;
            end
            if (pop) begin
                rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrOne;
            end
            if (push && !pop) begin
                count_d = count_q + CntOne;
            end else if (!push && pop) begin
                count_d = count_q - CntOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wptr_q] <= imem_rsp_data;
            pcs_q[wptr_q]  <= resp_pc_q;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit: pin-level vector table plus memory-model sequences.
module tb_riscv_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    riscv_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .fetch_fault   (fetch_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        redir;
        logic [31:0] rpc;
        logic        ir;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_ins;
        logic [31:0] exp_ipc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    int n_pass = 0;
    int n_total = 0;

    int unsigned cyc;
    int unsigned lat;
    int unsigned n_acc;
    logic        mem_ready;
    pend_t       pend[$];
    logic [31:0] acc_q[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_ins[$];
    vec_t        vecs[27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rd,
                                input logic redir, input logic [31:0] rpc, input logic ir,
                                input logic erv, input logic [31:0] eaddr, input logic eiv,
                                input logic [31:0] eins, input logic [31:0] eipc);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rd = rd; v.redir = redir; v.rpc = rpc; v.ir = ir;
        v.exp_rv = erv; v.exp_addr = eaddr; v.exp_iv = eiv; v.exp_ins = eins; v.exp_ipc = eipc;
        return v;
    endfunction

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        pend.delete();
        acc_q.delete();
        got_pc.delete();
        got_ins.delete();
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_valid", imem_req_valid, 32'h0);
        chk("rst_instr_valid", instr_valid, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_fault", fetch_fault, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        cyc   = 0;
        n_acc = 0;
        #1;
        chk("rst_addr", imem_req_addr, 32'h0);
    endtask

    // One clock with the latency-`lat` in-order memory model answering requests.
    task automatic cycle();
        logic acc, rspd, popd;
        logic [31:0] a, ipc, ins;
        imem_req_ready = mem_ready;
        if (pend.size() != 0 && pend[0].due <= cyc + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mdata(pend[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        acc  = imem_req_valid && imem_req_ready;
        a    = imem_req_addr;
        rspd = imem_rsp_valid;
        popd = instr_valid && instr_ready;
        ipc  = instr_pc;
        ins  = instr;
        @(posedge clk);
        cyc++;
        if (rspd) void'(pend.pop_front());
        if (acc) begin
            pend.push_back('{addr: a, due: cyc + lat});
            acc_q.push_back(a);
            n_acc++;
        end
        if (popd) begin
            got_pc.push_back(ipc);
            got_ins.push_back(ins);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        mem_ready = 1'b0;
        lat = 1;
        cyc = 0;
        n_acc = 0;
        @(negedge clk);

        //        rdy rv  rd            rdr rpc           ir  erv eaddr         eiv eins          eipc
        vecs[0]  = mk(1, 0, 32'h0,         0, 32'h0,         0,  1, 32'h0,         0, 32'h0,         32'h0);
        vecs[1]  = mk(1, 1, 32'h1111_0000, 0, 32'h0,         0,  1, 32'h4,         0, 32'h0,         32'h0);
        vecs[2]  = mk(1, 0, 32'h0,         0, 32'h0,         0,  0, 32'h8,         1, 32'h1111_0000, 32'h0);
        vecs[3]  = mk(1, 1, 32'h2222_0004, 0, 32'h0,         0,  0, 32'h8,         1, 32'h1111_0000, 32'h0);
        vecs[4]  = mk(1, 0, 32'h0,         0, 32'h0,         1,  0, 32'h8,         1, 32'h1111_0000, 32'h0);
        vecs[5]  = mk(0, 0, 32'h0,         0, 32'h0,         0,  1, 32'h8,         1, 32'h2222_0004, 32'h4);
        vecs[6]  = mk(1, 0, 32'h0,         1, 32'h100,       1,  0, 32'h8,         1, 32'h2222_0004, 32'h4);
        vecs[7]  = mk(1, 0, 32'h0,         0, 32'h0,         1,  1, 32'h100,       0, 32'h0,         32'h0);
        vecs[8]  = mk(1, 0, 32'h0,         0, 32'h0,         1,  1, 32'h104,       0, 32'h0,         32'h0);
        vecs[9]  = mk(1, 0, 32'h0,         0, 32'h0,         1,  0, 32'h108,       0, 32'h0,         32'h0);
        vecs[10] = mk(1, 1, 32'hBAD0_0100, 1, 32'h200,       1,  0, 32'h108,       0, 32'h0,         32'h0);
        vecs[11] = mk(1, 1, 32'hBAD0_0104, 0, 32'h0,         1,  1, 32'h200,       0, 32'h0,         32'h0);
        vecs[12] = mk(0, 1, 32'h3333_0200, 0, 32'h0,         1,  1, 32'h204,       0, 32'h0,         32'h0);
        vecs[13] = mk(0, 0, 32'h0,         0, 32'h0,         1,  1, 32'h204,       1, 32'h3333_0200, 32'h200);
        vecs[14] = mk(0, 0, 32'h0,         0, 32'h0,         1,  1, 32'h204,       0, 32'h0,         32'h0);
        vecs[15] = mk(1, 0, 32'h0,         0, 32'h0,         0,  1, 32'h204,       0, 32'h0,         32'h0);
        vecs[16] = mk(1, 1, 32'h4444_0204, 0, 32'h0,         0,  1, 32'h208,       0, 32'h0,         32'h0);
        vecs[17] = mk(1, 0, 32'h0,         0, 32'h0,         0,  0, 32'h20C,       1, 32'h4444_0204, 32'h204);
        vecs[18] = mk(1, 1, 32'hBAD0_0208, 1, 32'h300,       1,  0, 32'h20C,       1, 32'h4444_0204, 32'h204);
        vecs[19] = mk(1, 0, 32'h0,         0, 32'h0,         1,  1, 32'h300,       0, 32'h0,         32'h0);
        vecs[20] = mk(0, 1, 32'h5555_0300, 0, 32'h0,         1,  1, 32'h304,       0, 32'h0,         32'h0);
        vecs[21] = mk(0, 0, 32'h0,         0, 32'h0,         0,  1, 32'h304,       1, 32'h5555_0300, 32'h300);
        vecs[22] = mk(0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0,  0, 32'h304,       1, 32'h5555_0300, 32'h300);
        vecs[23] = mk(1, 0, 32'h0,         0, 32'h0,         0,  1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0);
        vecs[24] = mk(0, 1, 32'h6666_FFFC, 0, 32'h0,         0,  1, 32'h0,         0, 32'h0,         32'h0);
        vecs[25] = mk(0, 0, 32'h0,         0, 32'h0,         1,  1, 32'h0,         1, 32'h6666_FFFC, 32'hFFFF_FFFC);
        vecs[26] = mk(0, 0, 32'h0,         0, 32'h0,         0,  1, 32'h0,         0, 32'h0,         32'h0);

        do_reset();
        for (int i = 0; i < 27; i++) begin
            imem_req_ready = vecs[i].rdy;
            imem_rsp_valid = vecs[i].rv;
            imem_rsp_data  = vecs[i].rd;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            instr_ready    = vecs[i].ir;
            #1;
            chk($sformatf("vec%0d_req_valid", i), imem_req_valid, vecs[i].exp_rv);
            chk($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_instr_valid", i), instr_valid, vecs[i].exp_iv);
            chk($sformatf("vec%0d_instr", i), instr, vecs[i].exp_ins);
            chk($sformatf("vec%0d_instr_pc", i), instr_pc, vecs[i].exp_ipc);
            chk($sformatf("vec%0d_fault", i), fetch_fault, 32'h0);
            @(posedge clk);
            @(negedge clk);
        end

        // Streaming with 1-cycle memory and an always-ready decoder.
        do_reset();
        mem_ready = 1'b1;
        lat = 1;
        instr_ready = 1'b1;
        repeat (20) cycle();
        chk("stream_count_ge8", 32'(got_pc.size() >= 8), 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("stream_req%0d", i), q_at(acc_q, i), 32'(i * 4));
            chk($sformatf("stream_pc%0d", i), q_at(got_pc, i), 32'(i * 4));
            chk($sformatf("stream_ins%0d", i), q_at(got_ins, i), mdata(32'(i * 4)));
        end

        // Decoder backpressure: only DEPTH fetches may be taken.
        do_reset();
        mem_ready = 1'b1;
        lat = 1;
        instr_ready = 1'b0;
        repeat (10) cycle();
        #1;
        chk("bp_accepts", n_acc, 32'd2);
        chk("bp_req_valid", imem_req_valid, 32'h0);
        chk("bp_instr_valid", instr_valid, 32'h1);
        chk("bp_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        repeat (12) cycle();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_pc%0d", i), q_at(got_pc, i), 32'(i * 4));
            chk($sformatf("bp_ins%0d", i), q_at(got_ins, i), mdata(32'(i * 4)));
        end

        // Redirect with two fetches in flight on a 3-cycle memory.
        do_reset();
        mem_ready = 1'b1;
        lat = 3;
        instr_ready = 1'b1;
        repeat (2) cycle();
        chk("rd_inflight", n_acc, 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cycle();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (14) cycle();
        chk("rd_pc0", q_at(got_pc, 0), 32'h100);
        chk("rd_ins0", q_at(got_ins, 0), mdata(32'h100));
        chk("rd_pc1", q_at(got_pc, 1), 32'h104);
        chk("rd_ins1", q_at(got_ins, 1), mdata(32'h104));

        // Misaligned redirect.
        do_reset();
        mem_ready = 1'b0;
        lat = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        cycle();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_fault_set", fetch_fault, 32'h1);
        chk("mis_req_off", imem_req_valid, 32'h0);
        repeat (3) cycle();
        #1;
        chk("mis_fault_sticky", fetch_fault, 32'h1);
        chk("mis_req_still_off", imem_req_valid, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        cycle();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        chk("mis_fault_clr", fetch_fault, 32'h0);
        chk("mis_req_resume", imem_req_valid, 32'h1);
        chk("mis_addr_resume", imem_req_addr, 32'h200);
`else
        chk("mis_fault_tied", fetch_fault, 32'h0);
        chk("mis_req_on", imem_req_valid, 32'h1);
        chk("mis_addr_aligned", imem_req_addr, 32'h100);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
